// File: rtl/video_st_source.sv
// Camera-to-Avalon-ST bridge: captures one frame of pixels into a first-word
// fall-through buffer and always emits exactly WIDTH*HEIGHT beats per packet.
module video_st_source #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cam_frame_valid,
    input  logic        cam_line_valid,
    input  logic [23:0] cam_data,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    output logic [15:0] overflow_count,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] TOTAL_V = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_V  = CW'(TOTAL - 1);
    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2,
        PAD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_clr, cnt_inc, ovf_inc;
    logic          wr_en;
    logic [25:0]   wr_word;
    logic          pixel, at_total, is_first, is_last;

    logic [25:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   level;
    logic          full, pop;
    logic [25:0]   head;

    // Full is judged on the occupancy before this cycle's pop.
    assign full     = (level == DEPTH_V);
    assign src_valid = (level != '0);
    assign pop      = src_valid && src_ready;
    assign head     = mem[rd_ptr];

    assign pixel    = cam_frame_valid && cam_line_valid;
    assign at_total = (cnt_q == TOTAL_V);
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == LAST_V);

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_word = '0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        ovf_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cam_frame_valid) state_d = ARM;
            end
            ARM: begin
                cnt_clr = 1'b1;
                if (cam_frame_valid) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!cam_frame_valid) begin
                    state_d = at_total ? ARM : PAD;
                end else if (pixel && !at_total) begin
                    if (full) begin
                        ovf_inc = 1'b1;
                        state_d = PAD;
                    end else begin
                        wr_en   = 1'b1;
                        wr_word = {cam_data, is_first, is_last};
                        cnt_inc = 1'b1;
                    end
                end
            end
            PAD: begin
                // Zero-fill keeps every packet at full length after a short frame.
                if (at_total) begin
                    state_d = cam_frame_valid ? IDLE : ARM;
                end else if (!full) begin
                    wr_en   = 1'b1;
                    wr_word = {24'h000000, is_first, is_last};
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            overflow_count <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (ovf_inc && overflow_count != 16'hFFFF) begin
                overflow_count <= overflow_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop) begin
                level <= level + 1'b1;
            end else if (!wr_en && pop) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr] <= wr_word;
    end

    // Gate the head entry so stale storage never shows while empty.
    assign src_data          = src_valid ? head[25:2] : 24'h000000;
    assign src_startofpacket = src_valid && head[1];
    assign src_endofpacket   = src_valid && head[0];

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_video_st_source.sv
// Directed bench for video_st_source with a 4x2 frame and a 4-entry buffer.
module tb_video_st_source;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_ACTIVE = 2'd2, S_PAD = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cam_frame_valid = 1'b0;
    logic        cam_line_valid = 1'b0;
    logic [23:0] cam_data = '0;
    logic [23:0] src_data;
    logic        src_startofpacket, src_endofpacket, src_valid;
    logic        src_ready = 1'b1;
    logic [15:0] overflow_count;
    logic        busy;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;
    int hold_err = 0;
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    logic        prev_stall = 1'b0;
    logic [25:0] prev_word = '0;
    logic [25:0] cur_word;

    video_st_source #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .cam_frame_valid(cam_frame_valid), .cam_line_valid(cam_line_valid), .cam_data(cam_data),
        .src_data(src_data), .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
        .src_valid(src_valid), .src_ready(src_ready),
        .overflow_count(overflow_count), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    assign cur_word = {src_data, src_startofpacket, src_endofpacket};

    // Monitor: records accepted beats and flags any beat that moves while stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!src_valid || cur_word !== prev_word)) hold_err++;
            if (src_valid && src_ready) obs_q.push_back(cur_word);
            prev_stall = src_valid && !src_ready;
            prev_word  = cur_word;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cam_frame_valid = 1'b0;
        cam_line_valid = 1'b0;
        cam_data = '0;
        src_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_frame(input logic [23:0] base, input int npix, input int gap);
        cam_frame_valid = 1'b1;
        cam_line_valid = 1'b0;
        tick();
        for (int p = 0; p < npix; p++) begin
            cam_line_valid = 1'b1;
            cam_data = base + 24'(p);
            tick();
            if (((p + 1) % W == 0) && gap > 0 && (p + 1) < npix) begin
                cam_line_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        cam_line_valid = 1'b0;
        cam_frame_valid = 1'b0;
        cam_data = '0;
        tick();
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 300 && obs_q.size() < n; c++) tick();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cam_frame_valid = 1'b1;
        cam_line_valid = 1'b1;
        cam_data = 24'h5A5A5A;
        repeat (2) tick();
        n_vec++;
        if ({src_valid, src_startofpacket, src_endofpacket} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 000", {src_valid, src_startofpacket, src_endofpacket});
        end
        n_vec++;
        if (src_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h expected 000000", src_data); end
        n_vec++;
        if (overflow_count !== 16'h0) begin n_err++; $display("FAIL reset_ovf: got %0d expected 0", overflow_count); end
        n_vec++;
        if (busy !== 1'b0 || fsm_state !== S_IDLE) begin
            n_err++; $display("FAIL reset_state: got busy=%b state=%0d expected busy=0 state=0", busy, fsm_state);
        end
        reset = 1'b0;
        cam_frame_valid = 1'b0;
        cam_line_valid = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b1 || fsm_state !== S_ARM) begin
            n_err++; $display("FAIL reset_to_arm: got busy=%b state=%0d expected busy=1 state=1", busy, fsm_state);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cam_frame_valid = 1'b1;
        tick();
        n_vec++;
        if (fsm_state !== S_ACTIVE) begin n_err++; $display("FAIL lat_active: got state %0d expected 2", fsm_state); end
        cam_line_valid = 1'b1;
        cam_data = 24'hABCDEF;
        tick();
        n_vec++;
        if (src_valid !== 1'b1 || cur_word !== {24'hABCDEF, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL lat_one_cycle: got valid=%b word=%h expected valid=1 word=%h", src_valid, cur_word, {24'hABCDEF, 1'b1, 1'b0});
        end
        cam_line_valid = 1'b0;
        cam_frame_valid = 1'b0;
        tick();
    endtask

    task automatic test_clean_frame();
        do_reset();
        drive_frame(24'd1, 8, 0);
        wait_beats(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back({24'(i), (i == 1), (i == 8)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL clean_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clean_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++;
        if (overflow_count !== 16'h0) begin n_err++; $display("FAIL clean_ovf: got %0d expected 0", overflow_count); end
    endtask

    task automatic test_short_frame();
        do_reset();
        drive_frame(24'd1, 5, 0);
        wait_beats(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back({(i <= 5) ? 24'(i) : 24'h0, (i == 1), (i == 8)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL short_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL short_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++;
        if (fsm_state !== S_ARM) begin n_err++; $display("FAIL short_arm: got state %0d expected 1", fsm_state); end
    endtask

    task automatic test_overflow();
        do_reset();
        src_ready = 1'b0;
        drive_frame(24'd1, 8, 0);
        n_vec++;
        if (overflow_count !== 16'd1) begin n_err++; $display("FAIL ovf_count: got %0d expected 1", overflow_count); end
        n_vec++;
        if (fsm_state !== S_PAD) begin n_err++; $display("FAIL ovf_pad: got state %0d expected 3", fsm_state); end
        repeat (3) tick();
        n_vec++;
        if (src_valid !== 1'b1 || cur_word !== {24'd1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL ovf_hold: got valid=%b word=%h expected valid=1 word=%h", src_valid, cur_word, {24'd1, 1'b1, 1'b0});
        end
        src_ready = 1'b1;
        wait_beats(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back({(i <= 4) ? 24'(i) : 24'h0, (i == 1), (i == 8)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_beats: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++;
        if (fsm_state !== S_ARM || overflow_count !== 16'd1) begin
            n_err++; $display("FAIL ovf_end: got state=%0d ovf=%0d expected state=1 ovf=1", fsm_state, overflow_count);
        end
    endtask

    task automatic test_reset_in_frame();
        reset = 1'b1;
        src_ready = 1'b1;
        cam_frame_valid = 1'b1;
        cam_line_valid = 1'b0;
        repeat (2) tick();
        obs_q.delete();
        exp_q.delete();
        reset = 1'b0;
        drive_frame(24'h10, 8, 0);
        repeat (6) tick();
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL late_skip: got %0d beats expected 0", obs_q.size()); end
        n_vec++;
        if (fsm_state !== S_ARM) begin n_err++; $display("FAIL late_arm: got state %0d expected 1", fsm_state); end
        drive_frame(24'h20, 8, 0);
        wait_beats(8);
        for (int i = 0; i < 8; i++) exp_q.push_back({24'h20 + 24'(i), (i == 0), (i == 7)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL late_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL late_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ready_toggle();
        int hold_base;
        do_reset();
        hold_base = hold_err;
        fork
            drive_frame(24'd1, 8, 6);
            begin
                for (int i = 0; i < 40; i++) begin
                    src_ready = (i % 2 == 0);
                    tick();
                end
                src_ready = 1'b1;
            end
        join
        wait_beats(8);
        for (int i = 1; i <= 8; i++) exp_q.push_back({24'(i), (i == 1), (i == 8)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL toggle_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL toggle_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++;
        if (hold_err != hold_base) begin n_err++; $display("FAIL toggle_hold: got %0d unstable stalls expected 0", hold_err - hold_base); end
        n_vec++;
        if (overflow_count !== 16'h0) begin n_err++; $display("FAIL toggle_ovf: got %0d expected 0", overflow_count); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        cam_frame_valid = 1'b1;
        tick();
        for (int p = 1; p <= 8; p++) begin
            cam_line_valid = 1'b1;
            cam_data = 24'(p);
            tick();
            if (obs_q.size() >= 3) break;
        end
        reset = 1'b1;
        cam_frame_valid = 1'b0;
        cam_line_valid = 1'b0;
        cam_data = '0;
        tick();
        n_vec++;
        if (src_valid !== 1'b0 || cur_word !== 26'h0) begin
            n_err++; $display("FAIL mid_reset_out: got valid=%b word=%h expected valid=0 word=0", src_valid, cur_word);
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        n_vec++;
        if (obs_q.size() < 3 || obs_q.size() > 4) begin
            n_err++; $display("FAIL mid_trunc_count: got %0d beats expected 3 or 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i][0] !== 1'b0) begin n_err++; $display("FAIL mid_no_eop%0d: got eop=%b expected 0", i, obs_q[i][0]); end
        end
        reset = 1'b0;
        repeat (3) tick();
        obs_q.delete();
        drive_frame(24'h31, 8, 0);
        wait_beats(8);
        for (int i = 0; i < 8; i++) exp_q.push_back({24'h31 + 24'(i), (i == 0), (i == 7)});
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_next_count: got %0d beats expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_next_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_latency();
        test_clean_frame();
        test_short_frame();
        test_overflow();
        test_reset_in_frame();
        test_ready_toggle();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_st_source.md
VIDEO_ST_SOURCE -- requirements
Module: video_st_source

Interface
REQ-001 SHALL have parameter WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480: lines per frame; TOTAL = WIDTH*HEIGHT beats per packet.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two: output buffer entries.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cam_frame_valid  in  1  camera frame-active qualifier.
REQ-007 cam_line_valid  in  1  camera line-active qualifier; a pixel is present when both valids are high.
REQ-008 cam_data  in  24  RGB888 pixel.
REQ-009 src_data  out  24  Avalon-ST pixel to video DMA sink.
REQ-010 src_startofpacket  out  1  first beat of frame.
REQ-011 src_endofpacket  out  1  beat TOTAL-1 of frame.
REQ-012 src_valid  out  1  beat available.
REQ-013 src_ready  in  1  sink accepts the beat; ready latency 0.
REQ-014 overflow_count  out  16  saturating count of dropped camera pixels.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL be a state machine with states IDLE, ARM, ACTIVE, PAD.
REQ-017 IDLE: SHALL go to ARM when cam_frame_valid is low, so that a frame already in progress at reset exit is never captured.
REQ-018 ARM: SHALL go to ACTIVE on the cycle cam_frame_valid is sampled high; pixel counter cleared to 0.
REQ-019 ACTIVE: each pixel with counter < TOTAL and FIFO not full SHALL be written with sop=(counter==0) and eop=(counter==TOTAL-1), and the counter SHALL increment.
REQ-020 Pixels arriving when counter == TOTAL SHALL be discarded silently, with no overflow count.
REQ-021 A pixel arriving while the FIFO is full SHALL be discarded, SHALL increment overflow_count (saturating at 16'hFFFF), and SHALL move the FSM to PAD.
REQ-022 The FIFO-full test SHALL use the pre-pop occupancy; a simultaneous pop does not admit a write in that cycle.
REQ-023 ACTIVE: cam_frame_valid falling with counter < TOTAL SHALL move to PAD; with counter == TOTAL SHALL move to ARM.
REQ-024 PAD: each cycle the FIFO is not full, SHALL write 24'h000000 with sop/eop per REQ-019 and increment the counter.
REQ-025 PAD: when counter reaches TOTAL, SHALL go to ARM if cam_frame_valid is low, else to IDLE.
REQ-026 PAD: camera pixels SHALL be ignored and not counted as overflow.
REQ-027 Every emitted packet SHALL be exactly TOTAL beats, with SOP on beat 0 and EOP on beat TOTAL-1 only.
REQ-028 FIFO SHALL be first-word fall-through, 26 bits wide (data, sop, eop).
REQ-029 src_valid SHALL equal FIFO non-empty, with src_data, src_startofpacket and src_endofpacket from the head entry.
REQ-030 A pop SHALL occur when src_valid && src_ready.
REQ-031 Output beats SHALL hold stable while src_valid && !src_ready.
REQ-032 Latency: a pixel sampled into an empty FIFO at edge N SHALL appear with src_valid high after edge N, i.e. one cycle.
REQ-033 The pixel counter SHALL be ceil(log2(TOTAL+1)) bits wide and SHALL never wrap.

Reset
REQ-034 On reset: FSM to IDLE, counter 0, FIFO emptied.
REQ-035 On reset: src_valid 0, src_startofpacket 0, src_endofpacket 0, src_data 0, overflow_count 0, busy 0, all from the cycle after reset is sampled.
REQ-036 Reset mid-packet SHALL truncate the packet with no EOP issued; after reset, the next frame SHALL start with SOP after REQ-017/018.

Verification
REQ-037 WIDTH=4, HEIGHT=2, src_ready=1, one clean frame of pixels 1..8 -> 8 beats with data 1..8, SOP on beat 1, EOP on beat 8, overflow_count=0.
REQ-038 Same config, frame_valid drops after 5 pixels -> beats 1..5 followed by three zeros, EOP on beat 8, FSM returns to ARM.
REQ-039 FIFO_DEPTH=4, src_ready=0, continuous 8-pixel frame -> 4 beats buffered, overflow_count=1, pad fills once ready=1, 8 beats total: 1,2,3,4,0,0,0,0.
REQ-040 Reset deasserted while cam_frame_valid is already high -> no beats for that frame; the next frame is captured normally with SOP.
REQ-041 src_ready toggled 1/0 per cycle during a frame -> no beat lost or duplicated; data held stable while ready=0.
REQ-042 Reset asserted after beat 3 of 8 -> src_valid=0 the next cycle; the next frame is emitted with SOP and all 8 beats.
